weight_ram_writer: RTL and testbench



---
 rtl/weight_pkg.sv | 23 ++
 rtl/weight_ram_writer.sv | 145 ++++++++++++++
 tb/tb_weight_ram_writer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/weight_pkg.sv
// ----------------------------------------------------------------------------
// weight_pkg
// Shared definitions for the weight RAM load and fetch paths: frame sync
// bytes, loader state encoding and the parameter image size.
// ----------------------------------------------------------------------------
package weight_pkg;

   // Frame header bytes
   localparam logic [7:0] SYNC0 = 8'hA5;
   localparam logic [7:0] SYNC1 = 8'h5A;

   // Full parameter image size in bytes (also used by the fetch path)
   localparam int TOTAL_BYTES = 529;

   // Loader states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHECK   = 2'd3
   } wr_state_e;

endpackage

// File: rtl/weight_ram_writer.sv
// ----------------------------------------------------------------------------
// weight_ram_writer
// Accepts a framed byte stream (A5 5A, TOTAL_BYTES payload bytes, mod-256
// checksum) and writes payload byte k to weight RAM address k. `done` is
// raised only after a complete frame with a matching checksum; `err` flags
// a checksum failure or an in-frame timeout.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   s_valid/s_data   input byte stream, s_ready back-pressure (1 out of reset)
//   ram_we/addr/din  one-cycle RAM write strobe per payload byte
//   busy             a frame is in progress
//   done / err       result of the last frame (level, mutually exclusive)
// ----------------------------------------------------------------------------
module weight_ram_writer #(
   parameter int TOTAL_BYTES = weight_pkg::TOTAL_BYTES,
   parameter int ADDR_W      = 10,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              busy,
   output logic              done,
   output logic              err
);
   import weight_pkg::*;

   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W-1:0] LAST_CNT  = ADDR_W'(TOTAL_BYTES - 1);
   // The timeout fires on the edge at which the idle count would reach
   // TIMEOUT_CYC, i.e. while the registered count still holds TIMEOUT_CYC-1.
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              ready_q;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              beat;

   // Ready drops combinationally with reset so no beat is taken while
   // rst_n is low, and rises on the first edge after release.
   assign s_ready  = ready_q & rst_n;
   assign beat     = s_valid & s_ready;
   assign ram_we   = we_q;
   assign ram_addr = addr_q;
   assign ram_din  = din_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign err      = err_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         idle_q  <= '0;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         din_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         idle_q  <= idle_d;
         ready_q <= 1'b1;
         we_q    <= we_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      idle_d  = '0;
      we_d    = 1'b0;
      addr_d  = addr_q;
      din_d   = din_q;
      done_d  = done_q;
      err_d   = err_q;

      if (state_q != ST_IDLE && !beat) begin
         if (idle_q == IDLE_LAST) begin
            // Abort: RAM keeps what was written, result is an error.
            state_d = ST_IDLE;
            err_d   = 1'b1;
            done_d  = 1'b0;
         end else begin
            idle_d = idle_q + 1'b1;
         end
      end

      if (beat) begin
         unique case (state_q)
            ST_IDLE: begin
               if (s_data == SYNC0) state_d = ST_SYNC;
            end
            ST_SYNC: begin
               if (s_data == SYNC1) begin
                  state_d = ST_PAYLOAD;
                  cnt_d   = '0;
                  sum_d   = '0;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
               end else if (s_data != SYNC0) begin
                  state_d = ST_IDLE;
               end
            end
            ST_PAYLOAD: begin
               we_d   = 1'b1;
               addr_d = cnt_q;
               din_d  = s_data;
               sum_d  = sum_q + s_data;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               state_d = ST_IDLE;
               if (s_data == sum_q) done_d = 1'b1;
               else                 err_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_ram_writer.sv
module tb_weight_ram_writer;

   localparam int NB = 529;
   localparam int AW = 10;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic [7:0]    s_data = 8'h00;
   logic          s_ready;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          busy;
   logic          done;
   logic          err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [AW+7:0] wq[$];

   weight_ram_writer #(.TOTAL_BYTES(NB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_din(ram_din), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Record every write strobe, sampled mid-cycle.
   always @(negedge clk) if (ram_we === 1'b1) wq.push_back({ram_addr, ram_din});

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, exp finish");
      $fatal(1);
   end

   // Entries whose address/data differ from the expected k / k&FF sequence.
   function automatic int seq_errs();
      int e = 0;
      foreach (wq[i]) if (wq[i] !== {AW'(i), 8'(i)}) e++;
      return e;
   endfunction

   task automatic beat(input logic [7:0] b);
      s_valid = 1'b1;
      s_data  = b;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic payload(input int from, input int to, input bit gapped);
      for (int k = from; k < to; k++) begin
         beat(8'(k));
         if (gapped) idle(int'($urandom_range(1, 5)));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (s_ready !== 1'b0) $display("FAIL rst_ready: got %b exp 0", s_ready); else n_pass++;
      n_checks++;
      if ({ram_we, ram_addr, ram_din, busy, done, err} !== '0)
         $display("FAIL rst_outs: got we=%b a=%0d d=%0d b=%b dn=%b e=%b exp all 0",
                  ram_we, ram_addr, ram_din, busy, done, err);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_ready: got %b exp 1", s_ready); else n_pass++;
   endtask

   task automatic test_good_frame();
      wq.delete();
      beat(8'hA5);
      n_checks++; if (busy !== 1'b1) $display("FAIL good_busy_sync: got %b exp 1", busy); else n_pass++;
      beat(8'h5A);
      beat(8'h00);
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== 10'd0 || ram_din !== 8'h00)
         $display("FAIL good_first_write: got we=%b a=%0d d=%0d exp we=1 a=0 d=0", ram_we, ram_addr, ram_din);
      else n_pass++;
      payload(1, NB, 1'b0);
      n_checks++;
      if (ram_we !== 1'b1 || ram_addr !== 10'd528 || ram_din !== 8'h10 || done !== 1'b0)
         $display("FAIL good_last_write: got we=%b a=%0d d=%0d done=%b exp 1/528/16/0", ram_we, ram_addr, ram_din, done);
      else n_pass++;
      beat(8'h88);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || ram_we !== 1'b0)
         $display("FAIL good_result: got done=%b err=%b busy=%b we=%b exp 1/0/0/0", done, err, busy, ram_we);
      else n_pass++;
      idle(2);
      n_checks++; if (wq.size() !== NB) $display("FAIL good_wcount: got %0d exp %0d", wq.size(), NB); else n_pass++;
      n_checks++; if (seq_errs() !== 0) $display("FAIL good_wseq: got %0d bad exp 0", seq_errs()); else n_pass++;
   endtask

   task automatic test_bad_checksum();
      wq.delete();
      beat(8'hA5); beat(8'h5A);
      n_checks++;
      if (done !== 1'b0) $display("FAIL bad_done_cleared: got %b exp 0", done); else n_pass++;
      payload(0, NB, 1'b0);
      beat(8'h89);
      n_checks++;
      if (err !== 1'b1 || done !== 1'b0) $display("FAIL bad_result: got err=%b done=%b exp 1/0", err, done); else n_pass++;
      idle(1);
      n_checks++; if (wq.size() !== NB) $display("FAIL bad_wcount: got %0d exp %0d", wq.size(), NB); else n_pass++;
      beat(8'hA5); beat(8'h5A);
      n_checks++; if (err !== 1'b0) $display("FAIL bad_err_cleared: got %b exp 0", err); else n_pass++;
      payload(0, NB, 1'b0);
      beat(8'h88);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0) $display("FAIL bad_recover: got done=%b err=%b exp 1/0", done, err); else n_pass++;
   endtask

   task automatic test_false_sync();
      wq.delete();
      beat(8'h00); beat(8'hA5); beat(8'hA5); beat(8'h5A);
      payload(0, NB, 1'b0);
      beat(8'h88);
      idle(1);
      n_checks++;
      if (done !== 1'b1 || wq.size() !== NB)
         $display("FAIL fsync_accept: got done=%b writes=%0d exp 1/%0d", done, wq.size(), NB);
      else n_pass++;
      wq.delete();
      beat(8'hA5); beat(8'h33); beat(8'h5A);
      for (int k = 0; k < 4; k++) beat(8'(k));
      idle(2);
      n_checks++;
      if (wq.size() !== 0 || busy !== 1'b0 || done !== 1'b1)
         $display("FAIL fsync_reject: got writes=%0d busy=%b done=%b exp 0/0/1", wq.size(), busy, done);
      else n_pass++;
   endtask

   task automatic test_timeout();
      wq.delete();
      beat(8'hA5); beat(8'h5A);
      payload(0, 10, 1'b0);
      idle(TO - 1);
      n_checks++;
      if (busy !== 1'b1 || err !== 1'b0) $display("FAIL to_early: got busy=%b err=%b exp 1/0", busy, err); else n_pass++;
      idle(1);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
         $display("FAIL to_fire: got err=%b busy=%b done=%b exp 1/0/0", err, busy, done);
      else n_pass++;
      idle(5);
      n_checks++; if (wq.size() !== 10) $display("FAIL to_wcount: got %0d exp 10", wq.size()); else n_pass++;
   endtask

   task automatic test_gapped();
      wq.delete();
      beat(8'hA5); idle(3); beat(8'h5A); idle(2);
      payload(0, NB, 1'b1);
      beat(8'h88);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0) $display("FAIL gap_result: got done=%b err=%b exp 1/0", done, err); else n_pass++;
      idle(2);
      n_checks++; if (wq.size() !== NB) $display("FAIL gap_wcount: got %0d exp %0d", wq.size(), NB); else n_pass++;
      n_checks++; if (seq_errs() !== 0) $display("FAIL gap_wseq: got %0d bad exp 0", seq_errs()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      wq.delete();
      beat(8'hA5); beat(8'h5A);
      payload(0, 200, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({ram_we, ram_addr, ram_din, busy, done, err, s_ready} !== '0)
         $display("FAIL mid_rst_outs: got we=%b a=%0d d=%0d b=%b dn=%b e=%b rdy=%b exp all 0",
                  ram_we, ram_addr, ram_din, busy, done, err, s_ready);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (wq.size() !== 200) $display("FAIL mid_wcount: got %0d exp 200", wq.size()); else n_pass++;
      beat(8'hA5); beat(8'h5A);
      payload(0, NB, 1'b0);
      beat(8'h88);
      n_checks++;
      if (done !== 1'b1 || err !== 1'b0) $display("FAIL mid_recover: got done=%b err=%b exp 1/0", done, err); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_false_sync();
      test_timeout();
      test_gapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
